simon_core_param: RTL and testbench
===================================

// Module: simon_core_param
// PURPOSE
//  Parametrised, iterative SIMON 2N/MN block cipher core; successor to the fixed 48/96 core. Adds several rounds per cycle,
//  selectable z-sequence, stored round keys for fast encryption or decryption, and a status/mode output.
//  Sits between the host load/read handshake logic and the bus; one key context, one block in flight.
// PARAMETERS
//  N     24  word size in bits (16,24,32,48,64); block = 2N
//  M     4   key words (2,3,4); key = M*N
//  T     36  total rounds; must be a multiple of RPC
//  Co    6   round-counter width; 2**Co > T
//  ZSEQ  1   z-sequence index 0..4 (48/96 uses z1)
//  RPC   1   rounds per clock (1,2,3,4)
// PORTS
//  clk      in   1       clock, rising edge
//  R        in   1       synchronous reset, active high
//  newKey   in   1       KEY valid, request load
//  KEY      in   [M-1:0][N-1:0]  key words, KEY[0] = k0
//  loadKey  out  1       1-cycle pulse: KEY captured
//  doneKey  out  1       high while round keys are valid
//  newData  in   1       BLOCK valid, request processing
//  enc_dec  in   1       1 = encrypt, 0 = decrypt; sampled with BLOCK
//  BLOCK    in   [1:0][N-1:0]  [1] = x (upper), [0] = y
//  loadData out  1       1-cycle pulse: BLOCK captured
//  doneData out  1       outData valid; held until readData
//  readData in   1       host has consumed outData
//  outData  out  [1:0][N-1:0]  result, same packing as BLOCK
//  mode     out  [3:0]   one-hot state: {RUN,DONE,KEXP,READY}; 0 = IDLE
// BEHAVIOUR
//  Reset (sync, R=1): state IDLE; all outputs 0; round-key store invalid. R mid-operation aborts immediately; no partial result.
//  IDLE:  newKey -> capture KEY into rk[0..M-1], pulse loadKey, go KEXP. newData is ignored.
//  KEXP:  one key word per cycle, rk[i+M] for i=0..T-M-1, taking T-M cycles.
//    M=4: t=ror3(rk[i+3])^rk[i+1]; M=2/3: t=ror3(rk[i+M-1]). Then t^=ror1(t); rk[i+M]=~rk[i]^t^z[ZSEQ][i%62]^3.
//    On the last word: doneKey=1, go READY.
//  READY: newKey has priority -> doneKey=0, reload, KEXP. Otherwise newData -> capture BLOCK and enc_dec,
//    pulse loadData, go RUN.
//  RUN:   RPC rounds per cycle via chained simon_round instances; T/RPC cycles.
//    enc: round j uses rk[j], j ascending; x'=y^f(x)^k; y'=x.
//    dec: round keys descending; y'=x^f(y)^k; x'=y.
//    f(x)=(rol1 x & rol8 x)^rol2 x. After the last cycle: outData=result, doneData=1, go DONE.
//  DONE:  hold outData and doneData. readData=1 -> doneData=0 next cycle, go READY. newKey and newData are ignored.
//  Latency: newData to loadData is 1 cycle; loadData to doneData is T/RPC cycles.
//  Key load to doneKey: T-M+1 cycles.
//  Simultaneous newKey and newData in READY: the key wins; the block is taken after the next doneKey.
//  The host must hold newData until loadData and must drop readData before the next doneData. A held readData is
//  accepted only on a doneData rising.
//  Counter wraps never: RUN exits at T/RPC-1; KEXP index saturates at T-1.
// CONFIGURATION
//  SIMON_CBC_EN defined: extra input IV [1:0][N-1:0], latched into the chain register on loadKey.
//    enc: BLOCK^chain is enciphered; chain=outData.
//    dec: outData=decipher(BLOCK)^chain; chain=BLOCK.
//    The chain register resets to 0.
//  Not defined: pure ECB; the IV port and chain register are absent; otherwise identical.
// STRUCTURE
//  Package simon_pkg: typedef enum state_t {IDLE,READY,KEXP,DONE,RUN}; Z_SEQ[5] 62-bit constants;
//    functions rol/ror(word,n) parametrised on N.
//  Sub-module simon_round #(N): combinational single round, inputs x,y,k,enc_dec; RPC instances are chained.
//  Round-key store: T x N register array, written in IDLE/KEXP, read in RUN.
// TESTING
//  1 N=24,M=4,T=36,RPC=1; KEY 1a1918_121110_0a0908_020100, enc 726963_20646e -> outData 6e06a5_acf156;
//    doneKey 33 cycles after loadKey; doneData 36 cycles after loadData.
//  2 Same key, dec 6e06a5_acf156 -> 726963_20646e. Stream 5 blocks enc, then the same 5 blocks dec; all must match.
//  3 RPC=3 build, vectors from 1: identical outData; doneData 12 cycles after loadData.
//  4 R asserted 10 cycles into RUN -> next cycle mode=0 and doneData=0. newData without a new key is ignored
//    until newKey and doneKey.
//  5 newKey and newData both high in READY -> loadKey first; loadData only after doneKey=1. In DONE, newData is
//    ignored until readData.
//  6 SIMON_CBC_EN, IV 000000_000000: first block matches 1. Second identical plaintext gives a different cipher;
//    decrypting both restores the plaintext.

Source files
------------

// File: rtl/simon_pkg.sv
// simon_pkg: state encoding, z-sequences and rotate helpers shared by
// the parametrised SIMON core and its round function.
package simon_pkg;

    typedef enum logic [2:0] {IDLE, READY, KEXP, DONE, RUN} state_t;

    // Bit i of each constant is z_j[i] (sequence read LSB first).
    localparam logic [61:0] Z_SEQ [5] = '{
        62'b01100111000011010100100010111110110011100001101010010001011111,
        62'b01011010000110010011111011100010101101000011001001111101110001,
        62'b11001101101001111110001000010100011001001011000000111011110101,
        62'b11110000101100111001010001001000000111101001100011010111011011,
        62'b11110111001001010011000011101000000100011011010110011110001011
    };

    function automatic logic [63:0] rol(input logic [63:0] w, input int n,
                                        input int width);
        logic [63:0] m;
        logic [63:0] v;
        m = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        v = w & m;
        return ((v << n) | (v >> (width - n))) & m;
    endfunction

    function automatic logic [63:0] ror(input logic [63:0] w, input int n,
                                        input int width);
        logic [63:0] m;
        logic [63:0] v;
        m = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        v = w & m;
        return ((v >> n) | (v << (width - n))) & m;
    endfunction

endpackage

// File: rtl/simon_round.sv
// simon_round: one combinational SIMON round, forward or inverse,
// chained RPC times inside the core.
module simon_round
    import simon_pkg::*;
#(
    parameter int N = 24
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic [N-1:0] k,
    input  logic         enc_dec,
    output logic [N-1:0] xo,
    output logic [N-1:0] yo
);

    function automatic logic [N-1:0] rl(input logic [N-1:0] v, input int n);
        return N'(rol(64'(v), n, N));
    endfunction

    logic [N-1:0] fa;
    logic [N-1:0] fx;

    always_comb begin
        fa = enc_dec ? x : y;
        fx = (rl(fa, 1) & rl(fa, 8)) ^ rl(fa, 2);
        if (enc_dec) begin
            xo = y ^ fx ^ k;
            yo = x;
        end else begin
            xo = y;
            yo = x ^ fx ^ k;
        end
    end

endmodule

// File: rtl/simon_core_param.sv
// simon_core_param: iterative SIMON 2N/MN core with stored round keys.
// Define SIMON_CBC_EN to add the IV port and CBC chaining register.
module simon_core_param
    import simon_pkg::*;
#(
    parameter int N    = 24,
    parameter int M    = 4,
    parameter int T    = 36,
    parameter int Co   = 6,
    parameter int ZSEQ = 1,
    parameter int RPC  = 1
) (
    input  logic                 clk,
    input  logic                 R,
    input  logic                 newKey,
    input  logic [M-1:0][N-1:0]  KEY,
    output logic                 loadKey,
    output logic                 doneKey,
    input  logic                 newData,
    input  logic                 enc_dec,
    input  logic [1:0][N-1:0]    BLOCK,
    output logic                 loadData,
    output logic                 doneData,
    input  logic                 readData,
    output logic [1:0][N-1:0]    outData,
`ifdef SIMON_CBC_EN
    input  logic [1:0][N-1:0]    IV,
`endif
    output logic [3:0]           mode
);

    localparam int NC = T / RPC;

    function automatic logic [N-1:0] rr(input logic [N-1:0] v, input int n);
        return N'(ror(64'(v), n, N));
    endfunction

    state_t            state;
    state_t            nxt;
    logic              cap_key;
    logic              cap_blk;
    logic              fin;
    logic [Co-1:0]     kcnt;
    logic [Co-1:0]     ki;
    logic [Co-1:0]     rcnt;
    logic [5:0]        zi;
    logic              kfin;
    logic              dir;
    logic [N-1:0]      dx;
    logic [N-1:0]      dy;
    logic [N-1:0]      kt;
    logic [N-1:0]      kw;
    logic [N-1:0]      rk [T];
    logic [N-1:0]      cx [RPC+1];
    logic [N-1:0]      cy [RPC+1];
    logic [1:0][N-1:0] blk_in;
    logic [1:0][N-1:0] res;

    always_ff @(posedge clk) begin
        if (R) state <= IDLE;
        else   state <= nxt;
    end

    always_comb begin
        nxt     = state;
        cap_key = 1'b0;
        cap_blk = 1'b0;
        fin     = 1'b0;
        unique case (state)
            IDLE: begin
                if (newKey) begin
                    cap_key = 1'b1;
                    nxt     = KEXP;
                end
            end
            KEXP: begin
                if (kfin) nxt = READY;
            end
            READY: begin
                if (newKey) begin
                    cap_key = 1'b1;
                    nxt     = KEXP;
                end else if (newData) begin
                    cap_blk = 1'b1;
                    nxt     = RUN;
                end
            end
            RUN: begin
                if (rcnt == Co'(NC - 1)) begin
                    fin = 1'b1;
                    nxt = DONE;
                end
            end
            DONE: begin
                if (readData) nxt = READY;
            end
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        mode = 4'b0000;
        unique case (state)
            READY:   mode = 4'b0001;
            KEXP:    mode = 4'b0010;
            DONE:    mode = 4'b0100;
            RUN:     mode = 4'b1000;
            default: mode = 4'b0000;
        endcase
    end

    // Next key word rk[kcnt] from rk[kcnt-M .. kcnt-1].
    always_comb begin
        ki = kcnt - Co'(M);
        zi = (ki >= Co'(62)) ? 6'(ki - Co'(62)) : 6'(ki);
        kt = rr(rk[kcnt - Co'(1)], 3);
        if (M == 4) kt = kt ^ rk[ki + Co'(1)];
        kt = kt ^ rr(kt, 1);
        kw = ~rk[ki] ^ kt ^ N'(3) ^ N'(Z_SEQ[ZSEQ][zi]);
    end

    always_ff @(posedge clk) begin
        if (cap_key) begin
            for (int i = 0; i < M; i++) rk[i] <= KEY[i];
        end else if (state == KEXP && !kfin) begin
            rk[kcnt] <= kw;
        end
    end

    assign cx[0] = dx;
    assign cy[0] = dy;

    for (genvar r = 0; r < RPC; r++) begin : g_rnd
        logic [Co-1:0] fw;
        logic [Co-1:0] idx;
        assign fw  = Co'(int'(rcnt) * RPC + r);
        assign idx = dir ? fw : Co'(T - 1) - fw;
        simon_round #(.N(N)) u_round (
            .x      (cx[r]),
            .y      (cy[r]),
            .k      (rk[idx]),
            .enc_dec(dir),
            .xo     (cx[r+1]),
            .yo     (cy[r+1])
        );
    end

`ifdef SIMON_CBC_EN
    logic [1:0][N-1:0] chain;
    logic [1:0][N-1:0] cin;

    assign blk_in = enc_dec ? (BLOCK ^ chain) : BLOCK;
    assign res    = dir ? {cx[RPC], cy[RPC]} : ({cx[RPC], cy[RPC]} ^ chain);

    always_ff @(posedge clk) begin
        if (R) begin
            chain <= '0;
            cin   <= '0;
        end else begin
            if (cap_key) chain <= IV;
            if (cap_blk) cin   <= BLOCK;
            if (fin)     chain <= dir ? res : cin;
        end
    end
`else
    assign blk_in = BLOCK;
    assign res    = {cx[RPC], cy[RPC]};
`endif

    always_ff @(posedge clk) begin
        if (R) begin
            loadKey  <= 1'b0;
            loadData <= 1'b0;
            doneKey  <= 1'b0;
            doneData <= 1'b0;
            outData  <= '0;
            kcnt     <= '0;
            kfin     <= 1'b0;
            rcnt     <= '0;
            dir      <= 1'b0;
            dx       <= '0;
            dy       <= '0;
        end else begin
            loadKey  <= cap_key;
            loadData <= cap_blk;
            if (cap_key) begin
                doneKey <= 1'b0;
                kcnt    <= Co'(M);
                kfin    <= 1'b0;
            end else if (state == KEXP) begin
                if (kfin)                     doneKey <= 1'b1;
                else if (kcnt == Co'(T - 1)) kfin    <= 1'b1;
                else                          kcnt    <= kcnt + Co'(1);
            end
            if (cap_blk) begin
                dir  <= enc_dec;
                dx   <= blk_in[1];
                dy   <= blk_in[0];
                rcnt <= '0;
            end else if (state == RUN) begin
                dx   <= cx[RPC];
                dy   <= cy[RPC];
                rcnt <= rcnt + Co'(1);
            end
            if (fin) begin
                outData  <= res;
                doneData <= 1'b1;
            end else if (state == DONE && readData) begin
                doneData <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_simon_core_param.sv
// tb_simon_core_param: scoreboard bench for the SIMON 48/96 core,
// one instance at one round per clock and one at three.
module tb_simon_core_param;

    localparam int N = 24;
    localparam logic [95:0] KEY1 = 96'h1a1918_121110_0a0908_020100;
    localparam logic [47:0] PT1  = 48'h726963_20646e;
    localparam logic [47:0] CT1  = 48'h6e06a5_acf156;
    localparam logic [61:0] ZP   =
        62'b10001110111110010011000010110101000111011111001001100001011010;

    logic clk = 1'b0;
    logic R = 1'b1;
    logic newKey = 1'b0;
    logic newData = 1'b0;
    logic enc_dec = 1'b0;
    logic readData = 1'b0;
    logic [3:0][N-1:0] KEY = '0;
    logic [1:0][N-1:0] BLOCK = '0;
`ifdef SIMON_CBC_EN
    logic [1:0][N-1:0] IV = '0;
`endif

    logic loadKey, doneKey, loadData, doneData;
    logic [1:0][N-1:0] outData;
    logic [3:0] mode;
    logic loadKey3, doneKey3, loadData3, doneData3;
    logic [1:0][N-1:0] outData3;
    logic [3:0] mode3;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    logic [47:0] q1 [$];
    logic [47:0] q3 [$];
    logic [N-1:0] mk [36];
    logic [47:0] pts [5];
    logic [47:0] cts [5];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    simon_core_param #(.N(24), .M(4), .T(36), .Co(6), .ZSEQ(1), .RPC(1)) u1 (
        .clk(clk), .R(R), .newKey(newKey), .KEY(KEY), .loadKey(loadKey),
        .doneKey(doneKey), .newData(newData), .enc_dec(enc_dec), .BLOCK(BLOCK),
        .loadData(loadData), .doneData(doneData), .readData(readData),
        .outData(outData),
`ifdef SIMON_CBC_EN
        .IV(IV),
`endif
        .mode(mode)
    );

    simon_core_param #(.N(24), .M(4), .T(36), .Co(6), .ZSEQ(1), .RPC(3)) u3 (
        .clk(clk), .R(R), .newKey(newKey), .KEY(KEY), .loadKey(loadKey3),
        .doneKey(doneKey3), .newData(newData), .enc_dec(enc_dec), .BLOCK(BLOCK),
        .loadData(loadData3), .doneData(doneData3), .readData(readData),
        .outData(outData3),
`ifdef SIMON_CBC_EN
        .IV(IV),
`endif
        .mode(mode3)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [N-1:0] rl(input logic [N-1:0] v, input int n);
        return (v << n) | (v >> (N - n));
    endfunction

    function automatic logic [N-1:0] rr(input logic [N-1:0] v, input int n);
        return (v >> n) | (v << (N - n));
    endfunction

    function automatic logic [N-1:0] ff(input logic [N-1:0] v);
        return (rl(v, 1) & rl(v, 8)) ^ rl(v, 2);
    endfunction

    task automatic mkeys(input logic [95:0] key);
        logic [61:0] zp;
        logic [N-1:0] t;
        zp = ZP;
        for (int i = 0; i < 4; i++) mk[i] = key[i*24 +: 24];
        for (int i = 4; i < 36; i++) begin
            t = rr(mk[i-1], 3) ^ mk[i-3];
            t = t ^ rr(t, 1);
            mk[i] = 24'hfffffc ^ {23'b0, zp[61 - ((i - 4) % 62)]} ^ mk[i-4] ^ t;
        end
    endtask

    function automatic logic [47:0] mcrypt(input logic [47:0] b, input logic e);
        logic [N-1:0] x, y, t;
        x = b[47:24];
        y = b[23:0];
        if (e) begin
            for (int i = 0; i < 36; i++) begin
                t = x; x = y ^ ff(x) ^ mk[i]; y = t;
            end
        end else begin
            for (int i = 35; i >= 0; i--) begin
                t = y; y = x ^ ff(y) ^ mk[i]; x = t;
            end
        end
        return {x, y};
    endfunction

    function automatic logic sig(input int w);
        case (w)
            0: return loadKey;
            1: return doneKey;
            2: return loadData;
            default: return doneData;
        endcase
    endfunction

    task automatic wait_hi(input int w, input int lim, input string nm);
        int n;
        n = 0;
        while (sig(w) !== 1'b1 && n < lim) begin
            @(posedge clk); #1;
            n++;
        end
        if (sig(w) !== 1'b1) chk(nm, 64'(0), 64'(1));
    endtask

    task automatic monitor();
        logic pd1 = 1'b0, pd3 = 1'b0, pl1 = 1'b0, pl3 = 1'b0;
        int t1 = 0, t3 = 0;
        logic [47:0] e;
        forever begin
            @(negedge clk);
            if (loadData === 1'b1 && pl1 !== 1'b1) t1 = cyc;
            if (loadData3 === 1'b1 && pl3 !== 1'b1) t3 = cyc;
            if (doneData === 1'b1 && pd1 !== 1'b1) begin
                if (q1.size() == 0) chk("done1_unexpected", 64'(1), 64'(0));
                else begin
                    e = q1.pop_front();
                    chk("out_rpc1", 64'(outData), 64'(e));
                    chk("lat_rpc1", 64'(cyc - t1), 64'(36));
                end
            end
            if (doneData3 === 1'b1 && pd3 !== 1'b1) begin
                if (q3.size() == 0) chk("done3_unexpected", 64'(1), 64'(0));
                else begin
                    e = q3.pop_front();
                    chk("out_rpc3", 64'(outData3), 64'(e));
                    chk("lat_rpc3", 64'(cyc - t3), 64'(12));
                end
            end
            pl1 = loadData; pl3 = loadData3;
            pd1 = doneData; pd3 = doneData3;
        end
    endtask

    task automatic load_key(input logic [95:0] k);
        int t0;
        KEY = k; newKey = 1'b1;
        @(posedge clk); #1;
        wait_hi(0, 50, "loadKey_timeout");
        newKey = 1'b0;
        t0 = cyc;
        chk("mode_kexp", 64'(mode), 64'(4'b0010));
        @(posedge clk); #1;
        chk("loadKey_pulse", 64'(loadKey), 64'(0));
        wait_hi(1, 100, "doneKey_timeout");
        chk("kexp_latency", 64'(cyc - t0), 64'(33));
        chk("mode_ready", 64'(mode), 64'(4'b0001));
        chk("doneKey_rpc3", 64'(doneKey3), 64'(1));
    endtask

    task automatic send(input logic [47:0] b, input logic e,
                        input logic [47:0] exp);
        q1.push_back(exp); q3.push_back(exp);
        BLOCK = b; enc_dec = e; newData = 1'b1;
        @(posedge clk); #1;
        wait_hi(2, 200, "loadData_timeout");
        newData = 1'b0;
        wait_hi(3, 200, "doneData_timeout");
        readData = 1'b1;
        @(posedge clk); #1;
        readData = 1'b0;
    endtask

    task automatic key_then_block(input logic [47:0] b, input logic [47:0] exp);
        int n;
        logic seen;
        q1.push_back(exp); q3.push_back(exp);
        KEY = KEY1; BLOCK = b; enc_dec = 1'b1;
        newKey = 1'b1; newData = 1'b1;
        @(posedge clk); #1;
        chk("kb_loadKey", 64'(loadKey), 64'(1));
        chk("kb_no_loadData", 64'(loadData), 64'(0));
        newKey = 1'b0;
        n = 0; seen = 1'b0;
        while (doneKey !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            if (loadData === 1'b1) seen = 1'b1;
            n++;
        end
        chk("kb_doneKey", 64'(doneKey), 64'(1));
        chk("kb_early_loadData", 64'(seen), 64'(0));
        @(posedge clk); #1;
        chk("kb_loadData", 64'(loadData), 64'(1));
        newData = 1'b0;
        wait_hi(3, 200, "kb_doneData_timeout");
        readData = 1'b1;
        @(posedge clk); #1;
        readData = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        logic [47:0] c2;
        fork
            monitor();
        join_none
        pts[0] = 48'h000000_000000; pts[1] = 48'hffffff_ffffff;
        pts[2] = 48'h123456_abcdef; pts[3] = 48'h800000_000001;
        pts[4] = PT1;
        mkeys(KEY1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mode", 64'(mode), 64'(0));
        chk("rst_mode3", 64'(mode3), 64'(0));
        chk("rst_flags", 64'({loadKey, doneKey, loadData, doneData}), 64'(0));
        chk("rst_out", 64'(outData), 64'(0));
        R = 1'b0;
        load_key(KEY1);
`ifdef SIMON_CBC_EN
        c2 = mcrypt(PT1 ^ CT1, 1'b1);
        send(PT1, 1'b1, CT1);
        send(PT1, 1'b1, c2);
        load_key(KEY1);
        send(CT1, 1'b0, PT1);
        send(c2, 1'b0, PT1);
`else
        c2 = '0;
        send(PT1, 1'b1, CT1);
        send(CT1, 1'b0, PT1);
        for (int i = 0; i < 5; i++) begin
            cts[i] = mcrypt(pts[i], 1'b1);
            send(pts[i], 1'b1, cts[i]);
        end
        for (int i = 0; i < 5; i++) send(cts[i], 1'b0, pts[i]);

        BLOCK = PT1; enc_dec = 1'b1; newData = 1'b1;
        @(posedge clk); #1;
        wait_hi(2, 50, "abort_loadData_timeout");
        newData = 1'b0;
        chk("mode_run", 64'(mode), 64'(4'b1000));
        repeat (10) @(posedge clk);
        #1;
        R = 1'b1;
        @(posedge clk); #1;
        chk("abort_mode", 64'(mode), 64'(0));
        chk("abort_doneData", 64'(doneData), 64'(0));
        chk("abort_doneKey", 64'(doneKey), 64'(0));
        R = 1'b0;
        newData = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (loadData === 1'b1 || mode !== 4'b0000) seen++;
        end
        chk("idle_ignores_data", 64'(seen), 64'(0));
        key_then_block(PT1, CT1);

        key_then_block(pts[2], cts[2]);

        q1.push_back(cts[3]); q3.push_back(cts[3]);
        q1.push_back(cts[0]); q3.push_back(cts[0]);
        BLOCK = pts[3]; enc_dec = 1'b1; newData = 1'b1;
        @(posedge clk); #1;
        wait_hi(2, 50, "d1_loadData_timeout");
        newData = 1'b0;
        wait_hi(3, 200, "d1_doneData_timeout");
        BLOCK = pts[0]; newData = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (loadData === 1'b1 || mode !== 4'b0100) seen++;
        end
        chk("done_ignores_data", 64'(seen), 64'(0));
        chk("done_held", 64'(doneData), 64'(1));
        readData = 1'b1;
        @(posedge clk); #1;
        readData = 1'b0;
        chk("read_clears_done", 64'(doneData), 64'(0));
        wait_hi(2, 10, "d2_loadData_timeout");
        newData = 1'b0;
        wait_hi(3, 200, "d2_doneData_timeout");
        readData = 1'b1;
        @(posedge clk); #1;
        readData = 1'b0;
`endif
        repeat (20) @(posedge clk);
        #1;
        chk("q1_empty", 64'(q1.size()), 64'(0));
        chk("q3_empty", 64'(q3.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
